// File: rtl/risc16_pkg.sv
// Shared encodings for the risc16 memory responder: FSM states, bus direction
// and the read data substituted when a bus phase times out.
package risc16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DATA    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [15:0] BUS_ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/risc16_bus_timer.sv
// Per-phase bus wait timer: down-counter reloaded with TIMEOUT, expires at zero.
// Instantiated only when RISC16_BUS_TIMEOUT_EN is defined.
module risc16_bus_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= CW'(TIMEOUT);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/risc16_mem_responder.sv
// Serialises risc16 fetch and data accesses onto one handshaked memory bus and
// stalls the core until both complete. Optional bus timeout: RISC16_BUS_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | core halted, waiting for dbg_halt to drop
// FETCH   | instruction read at cpu_pc, waiting for ack
// DATA    | load/store at cpu_addr, waiting for ack
// RELEASE | cpu_halt low for one commit cycle
module risc16_mem_responder
    import risc16_pkg::*;
#(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dbg_halt,
    input  logic [AW-1:0] cpu_pc,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_rw,
    output logic [DW-1:0] cpu_ir,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_halt,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          bus_err
);

    state_t        state, state_next;
    logic          phase_done;
    logic          timeout;
    logic [DW-1:0] resp_data;

`ifdef RISC16_BUS_TIMEOUT_EN
    logic in_phase;
    logic tmr_expired;

    assign in_phase = (state == ST_FETCH) || (state == ST_DATA);

    // Reload whenever outside a phase or finishing one, so the next phase starts fresh.
    risc16_bus_timer #(.TIMEOUT(TIMEOUT)) u_bus_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (!in_phase || phase_done),
        .dec     (in_phase && !phase_done),
        .expired (tmr_expired)
    );

    assign timeout   = in_phase && tmr_expired && !mem_ack;
    assign resp_data = timeout ? DW'(BUS_ERR_DATA) : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if (timeout) begin
            bus_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout        = 1'b0;
    assign resp_data      = mem_rdata;
    assign bus_err        = 1'b0;
`endif

    assign phase_done = mem_ack || timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cpu_halt   = 1'b1;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = cpu_pc;
        mem_wdata  = cpu_wdata;
        unique case (state)
            ST_IDLE: begin
                if (!dbg_halt) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (phase_done) state_next = ST_DATA;
            end
            ST_DATA: begin
                mem_req  = 1'b1;
                mem_addr = cpu_addr;
                mem_we   = (cpu_rw == RW_WRITE);
                if (phase_done) state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                cpu_halt   = 1'b0;
                state_next = dbg_halt ? ST_IDLE : ST_FETCH;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_ir    <= '0;
            cpu_rdata <= '0;
        end else if (phase_done) begin
            if (state == ST_FETCH) begin
                cpu_ir <= resp_data;
            end
            if ((state == ST_DATA) && (cpu_rw == RW_READ)) begin
                cpu_rdata <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_risc16_mem_responder.sv
// Directed bench for risc16_mem_responder; timeout scenario runs only when
// RISC16_BUS_TIMEOUT_EN is defined (TIMEOUT forced to 8).
module tb_risc16_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_halt;
    logic [15:0] cpu_pc, cpu_addr, cpu_wdata;
    logic        cpu_rw;
    logic [15:0] cpu_ir, cpu_rdata;
    logic        cpu_halt;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    risc16_mem_responder #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .dbg_halt  (dbg_halt),
        .cpu_pc    (cpu_pc),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rw    (cpu_rw),
        .cpu_ir    (cpu_ir),
        .cpu_rdata (cpu_rdata),
        .cpu_halt  (cpu_halt),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        int halt_low;
        int held;
        int we_cnt;
        logic seen;

        rst = 1'b1; dbg_halt = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1234;
        cpu_pc = 16'h000F; cpu_addr = 16'h0010; cpu_wdata = 16'h0000; cpu_rw = 1'b0;

        // 1: reset state, zero-wait throughput
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_halt", cpu_halt, 1);
        check_eq("rst_req", mem_req, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_ir", cpu_ir, 0);
        check_eq("rst_rdata", cpu_rdata, 0);
        check_eq("rst_bus_err", bus_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t1_fetch_req", mem_req, 1);
        check_eq("t1_fetch_we", mem_we, 0);
        check_eq("t1_fetch_addr", mem_addr, 16'h000F);
        check_eq("t1_fetch_halt", cpu_halt, 1);
        @(negedge clk);
        check_eq("t1_ir", cpu_ir, 16'h1234);
        check_eq("t1_data_addr", mem_addr, 16'h0010);
        check_eq("t1_data_req", mem_req, 1);
        @(negedge clk);
        check_eq("t1_release_halt", cpu_halt, 0);
        check_eq("t1_release_req", mem_req, 0);
        check_eq("t1_rdata", cpu_rdata, 16'h1234);
        halt_low = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (cpu_halt == 1'b0) halt_low++;
        end
        check_eq("t1_halt_low_per_9", halt_low, 3);
        check_eq("t1_ends_release", cpu_halt, 0);

        // 2: DATA read with ack delayed 4 cycles
        cpu_pc = 16'h0020; cpu_addr = 16'h0040; mem_rdata = 16'h5555; mem_ack = 1'b1;
        @(negedge clk);
        check_eq("t2_fetch_addr", mem_addr, 16'h0020);
        @(negedge clk);
        check_eq("t2_ir", cpu_ir, 16'h5555);
        mem_ack = 1'b0; mem_rdata = 16'hBEEF;
        held = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req && mem_addr == 16'h0040 && cpu_halt) held++;
            mem_ack = (i == 4);
            @(negedge clk);
        end
        check_eq("t2_req_held", held, 5);
        check_eq("t2_release_halt", cpu_halt, 0);
        check_eq("t2_release_req", mem_req, 0);
        check_eq("t2_rdata", cpu_rdata, 16'hBEEF);

        // 3: store, one acked write cycle, load data untouched
        cpu_pc = 16'h0030; mem_rdata = 16'h7777; mem_ack = 1'b1;
        cpu_rw = 1'b1; cpu_addr = 16'h0080; cpu_wdata = 16'h00AA;
        we_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!cpu_halt) begin
                seen = 1'b1;
                break;
            end
            if (mem_req && mem_we && mem_ack) begin
                we_cnt++;
                check_eq("t3_wr_addr", mem_addr, 16'h0080);
                check_eq("t3_wr_data", mem_wdata, 16'h00AA);
            end
        end
        check_eq("t3_release_seen", seen, 1);
        check_eq("t3_write_cycles", we_cnt, 1);
        check_eq("t3_rdata_kept", cpu_rdata, 16'hBEEF);
        check_eq("t3_ir", cpu_ir, 16'h7777);

        // 4: dbg_halt raised during DATA
        cpu_rw = 1'b0; cpu_addr = 16'h0050; cpu_pc = 16'h0040; mem_rdata = 16'h4321; mem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dbg_halt = 1'b1; mem_ack = 1'b0;
        check_eq("t4_data_req", mem_req, 1);
        @(negedge clk);
        check_eq("t4_data_req_held", mem_req, 1);
        check_eq("t4_data_addr", mem_addr, 16'h0050);
        mem_ack = 1'b1;
        @(negedge clk);
        check_eq("t4_release_halt", cpu_halt, 0);
        check_eq("t4_rdata", cpu_rdata, 16'h4321);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t4_idle_req", mem_req, 0);
            check_eq("t4_idle_halt", cpu_halt, 1);
        end
        dbg_halt = 1'b0;
        @(negedge clk);
        check_eq("t4_resume_req", mem_req, 1);
        check_eq("t4_resume_addr", mem_addr, 16'h0040);

        // 5: reset mid-FETCH with ack withheld
        mem_ack = 1'b0;
        @(negedge clk);
        check_eq("t5_fetch_wait_req", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_req", mem_req, 0);
        check_eq("t5_rst_halt", cpu_halt, 1);
        check_eq("t5_rst_ir", cpu_ir, 0);
        check_eq("t5_rst_rdata", cpu_rdata, 0);
        rst = 1'b0;

`ifdef RISC16_BUS_TIMEOUT_EN
        // 6: timeout on both phases, TIMEOUT = 8
        begin
            int fetch_cnt;
            int data_cnt;
            cpu_pc = 16'h0100; cpu_addr = 16'h0200; cpu_rw = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
            fetch_cnt = 0; data_cnt = 0; seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!cpu_halt) begin
                    seen = 1'b1;
                    break;
                end
                if (mem_req && mem_addr == 16'h0100) fetch_cnt++;
                else if (mem_req && mem_addr == 16'h0200) data_cnt++;
            end
            check_eq("t6_release_seen", seen, 1);
            check_eq("t6_fetch_cycles", fetch_cnt, 9);
            check_eq("t6_data_cycles", data_cnt, 9);
            check_eq("t6_ir", cpu_ir, 16'hFFFF);
            check_eq("t6_rdata", cpu_rdata, 16'hFFFF);
            check_eq("t6_bus_err", bus_err, 1);
            mem_ack = 1'b1;
            repeat (4) @(negedge clk);
            check_eq("t6_bus_err_sticky", bus_err, 1);
            rst = 1'b1;
            @(negedge clk);
            check_eq("t6_bus_err_rst", bus_err, 0);
            rst = 1'b0;
        end
`else
        mem_ack = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("no_timeout_req_held", mem_req, 1);
        check_eq("no_timeout_bus_err", bus_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
